regfile_mp: RTL

//  Multi-port register file for the decode stage: NREAD combinational read ports, NWRITE sync write ports,
//  per-register busy scoreboard for hazard detection. Sequential clear FSM zeroes one entry per cycle,
//  so storage maps to RAM, not flops. Register 0 reads as zero and is never written or marked busy.

---
 rtl/regfile_mp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_mp                                                      |
// | Purpose  : multi-port register file with busy scoreboard and sequential    |
// |            clear; optional write-first bypass under REGFILE_BYPASS_EN.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int ADDR  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    ready,
  input  logic [NREAD*ADDR-1:0]   rreg,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       regwrite,
  input  logic [NWRITE*ADDR-1:0]  wreg,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  input  logic                    claim,
  input  logic [ADDR-1:0]         claim_reg
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [ADDR-1:0]  cnt, cnt_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [NWRITE-1:0] we;
  logic             claim_ok;

  assign ready = (state == RUN);

  // A clear request in RUN drops that cycle's writes and claims.
  genvar gw;
  generate
    for (gw = 0; gw < NWRITE; gw++) begin : g_we
      assign we[gw] = (state == RUN) && !clear && regwrite[gw] &&
                      (wreg[gw*ADDR +: ADDR] != '0);
    end
  endgenerate

  assign claim_ok = (state == RUN) && !clear && claim && (claim_reg != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (clear) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // No reset on storage so it can map onto RAM; higher write port wins.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end
    for (int i = 0; i < NWRITE; i++) begin
      if (we[i]) begin
        mem[wreg[i*ADDR +: ADDR]] <= wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Claim is applied after the write clears so a same-edge claim keeps busy set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (clear) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (we[i]) begin
          busy[wreg[i*ADDR +: ADDR]] <= 1'b0;
        end
      end
      if (claim_ok) begin
        busy[claim_reg] <= 1'b1;
      end
      busy[0] <= 1'b0;
    end
  end

  genvar gr;
  generate
    for (gr = 0; gr < NREAD; gr++) begin : g_rd
      logic [ADDR-1:0]  ra;
      logic [WIDTH-1:0] d;
      logic             b;

      assign ra = rreg[gr*ADDR +: ADDR];

      always_comb begin
        d = mem[ra];
        b = busy[ra];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWRITE; i++) begin
          if (we[i] && (wreg[i*ADDR +: ADDR] == ra)) begin
            d = wdata[i*WIDTH +: WIDTH];
            b = claim_ok && (claim_reg == ra);
          end
        end
`else
        d = d;
        b = b;
`endif
        if ((state == CLEAR) || (ra == '0)) begin
          d = '0;
          b = 1'b0;
        end
      end

      assign rdata[gr*WIDTH +: WIDTH] = d;
      assign rbusy[gr]                = b;
    end
  endgenerate

endmodule
`default_nettype wire
